pipe_hazard_ctrl: RTL

Hazard and sequencing controller for the 3-stage core pipeline: D (fetch/decode), E (execute) and W (write).
- Keeps a small scoreboard of in-flight destination registers.
- Drives the per-operand forwarding selects into execute.
- Stalls D on load-use hazards and squashes wrong-path instructions after a taken branch.
- Replaces the static forwarding flags currently produced by control.

---
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute handshake between the core pipeline and the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned STAT_W     = 16
);
  logic                  dec_valid;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic                  dec_use_rs1;
  logic                  dec_use_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_wr_rd;
  logic                  dec_is_load;
  logic                  ex_branch_taken;
  logic                  stall_d;
  logic                  bubble_e;
  logic                  flush_d;
  logic [1:0]            fwd_rs1;
  logic [1:0]            fwd_rs2;
  logic                  busy;
  logic [STAT_W-1:0]     stat_stalls;
  logic [STAT_W-1:0]     stat_flushes;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_rd, dec_wr_rd, dec_is_load, ex_branch_taken,
    input  stall_d, bubble_e, flush_d, fwd_rs1, fwd_rs2, busy,
           stat_stalls, stat_flushes
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_rd, dec_wr_rd, dec_is_load, ex_branch_taken,
    output stall_d, bubble_e, flush_d, fwd_rs1, fwd_rs2, busy,
           stat_stalls, stat_flushes
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the D/E/W pipeline: scoreboard, forwarding, load-use stall, branch squash.
// Optional statistics counters are built only when PIPE_HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STAT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {ST_RUN, ST_LDSTALL, ST_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                  ex_v, ex_wr, ex_ld;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  wb_v, wb_wr;
  logic [REG_ADDR_W-1:0] wb_rd;

  logic use1, use2, me1, me2, mw1, mw2, hazard;
  logic hz_stall, hz_bubble, hz_flush, hz_busy, load_e;
  logic [1:0] fwd1, fwd2;

  // Scoreboard matches; x0 never matches
  assign use1   = bus.dec_valid & bus.dec_use_rs1;
  assign use2   = bus.dec_valid & bus.dec_use_rs2;
  assign me1    = ex_v & ex_wr & (ex_rd == bus.dec_rs1) & (|bus.dec_rs1);
  assign me2    = ex_v & ex_wr & (ex_rd == bus.dec_rs2) & (|bus.dec_rs2);
  assign mw1    = wb_v & wb_wr & (wb_rd == bus.dec_rs1) & (|bus.dec_rs1);
  assign mw2    = wb_v & wb_wr & (wb_rd == bus.dec_rs2) & (|bus.dec_rs2);
  assign hazard = ex_ld & ((use1 & me1) | (use2 & me2));

  // Forwarding selects, E result has priority over W data
  always_comb begin
    fwd1 = 2'b00;
    fwd2 = 2'b00;
    if (use1) begin
      if (me1 && !ex_ld) fwd1 = 2'b01;
      else if (mw1)      fwd1 = 2'b10;
    end
    if (use2) begin
      if (me2 && !ex_ld) fwd2 = 2'b01;
      else if (mw2)      fwd2 = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.ex_branch_taken) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end else if (hazard) begin
          state_d = ST_LDSTALL;
        end
      end
      ST_LDSTALL: state_d = ST_RUN;
      ST_FLUSH: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // A branch in the same cycle as a load-use squashes the hazarding instruction instead of stalling
  always_comb begin
    hz_stall  = 1'b0;
    hz_bubble = 1'b0;
    hz_flush  = 1'b0;
    hz_busy   = (state_q != ST_RUN);
    unique case (state_q)
      ST_RUN: begin
        hz_flush  = bus.ex_branch_taken;
        hz_stall  = hazard & ~bus.ex_branch_taken;
        hz_bubble = hazard & ~bus.ex_branch_taken;
      end
      ST_FLUSH: hz_flush = (cnt_q != '0);
      default: ;
    endcase
  end

  assign load_e = bus.dec_valid & ~hz_stall & ~hz_bubble & ~hz_flush;

  // E slot captures D or a bubble; W always takes E
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v  <= 1'b0;
      ex_wr <= 1'b0;
      ex_ld <= 1'b0;
      ex_rd <= '0;
      wb_v  <= 1'b0;
      wb_wr <= 1'b0;
      wb_rd <= '0;
    end else begin
      wb_v  <= ex_v;
      wb_wr <= ex_wr;
      wb_rd <= ex_rd;
      ex_v  <= load_e;
      ex_wr <= load_e & bus.dec_wr_rd;
      ex_ld <= load_e & bus.dec_is_load;
      ex_rd <= load_e ? bus.dec_rd : '0;
    end
  end

  assign bus.stall_d  = hz_stall;
  assign bus.bubble_e = hz_bubble;
  assign bus.flush_d  = hz_flush;
  assign bus.fwd_rs1  = fwd1;
  assign bus.fwd_rs2  = fwd2;
  assign bus.busy     = hz_busy;

`ifdef PIPE_HAZARD_STATS_EN
  logic [STAT_W-1:0] stalls_q, flushes_q;
  logic              ld_entry;

  assign ld_entry = (state_q == ST_RUN) && (state_d == ST_LDSTALL);

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (ld_entry && !(&stalls_q))  stalls_q  <= stalls_q + STAT_W'(1);
      if (hz_flush && !(&flushes_q)) flushes_q <= flushes_q + STAT_W'(1);
    end
  end

  assign bus.stat_stalls  = stalls_q;
  assign bus.stat_flushes = flushes_q;
`else
  assign bus.stat_stalls  = STAT_W'(0);
  assign bus.stat_flushes = STAT_W'(0);
`endif
endmodule
